// File: rtl/regfile_pkg.sv
// Shared defaults and types for the integer register file.
package regfile_pkg;

  localparam int unsigned DEF_XLEN            = 32;
  localparam int unsigned DEF_NUM_REGS        = 32;
  localparam int unsigned DEF_NUM_RD          = 2;
  localparam int unsigned DEF_SP_IDX          = 2;
  localparam int unsigned DEF_ADDR_WIDTH_DMEM = 10;
  localparam int unsigned REG_AW              = $clog2(DEF_NUM_REGS);

  typedef logic [REG_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bit per register: set on issue, cleared on writeback commit, wiped on flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                async_reset,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_q;

  // Clear is applied before set so a same-cycle issue to the committing register stays busy.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) busy_q[wr_addr] <= 1'b0;
      if (issue_en && (issue_addr != '0)) busy_q[issue_addr] <= 1'b1;
    end
  end

  assign busy = {busy_q[NUM_REGS-1:1], 1'b0};

endmodule

// File: rtl/regfile_bank.sv
// Integer register file: NUM_RD bypassed combinational read ports, one write port,
// x0 hardwired to zero, stack-pointer reset value and a hazard scoreboard.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN            = DEF_XLEN,
  parameter int unsigned NUM_REGS        = DEF_NUM_REGS,
  parameter int unsigned NUM_RD          = DEF_NUM_RD,
  parameter int unsigned SP_IDX          = DEF_SP_IDX,
  parameter int unsigned ADDR_WIDTH_DMEM = DEF_ADDR_WIDTH_DMEM,
  localparam int unsigned AW             = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   async_reset,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_addr,
  input  logic                   flush
);

  // 2**ADDR_WIDTH_DMEM truncated to XLEN bits.
  localparam logic [XLEN-1:0] SP_RST =
    (ADDR_WIDTH_DMEM < XLEN) ? (XLEN'(1) << ADDR_WIDTH_DMEM) : '0;

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      regs_q[SP_IDX] <= SP_RST;
    end else if (wr_en && (wr_addr != '0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .async_reset (async_reset),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .flush       (flush),
    .busy        (busy)
  );

  // A same-cycle commit forwards its data and hides the busy bit it is about to clear.
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rd_addr[k*AW +: AW];
    assign hit  = wr_en && (wr_addr == addr);
    assign rd_data[k*XLEN +: XLEN] = (addr == '0) ? '0 : (hit ? wr_data : regs_q[addr]);
    assign rd_busy[k]              = busy[addr] & ~hit;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Directed vector bench for regfile_bank with default parameters.
module tb_regfile_bank;
  import regfile_pkg::*;

  logic           clk = 1'b0;
  logic           async_reset;
  logic [9:0]     rd_addr;
  logic [63:0]    rd_data;
  logic [1:0]     rd_busy;
  logic           wr_en;
  logic [4:0]     wr_addr;
  logic [31:0]    wr_data;
  logic           issue_en;
  logic [4:0]     issue_addr;
  logic           flush;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
  } vec_t;

  vec_t vq[$];

  regfile_bank dut (
    .clk         (clk),
    .async_reset (async_reset),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_en    (issue_en),
    .issue_addr  (issue_addr),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic ie, input logic [4:0] ia, input logic fl,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] b);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.b = b;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rd_addr = '0;
    async_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset = 1'b1;
    @(negedge clk);

    // Reset image on both ports
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(r), 5'(r)};
      #1;
      check($sformatf("rst_p0_x%0d", r), rd_data[31:0],  (r == 2) ? 32'h400 : 32'h0);
      check($sformatf("rst_p1_x%0d", r), rd_data[63:32], (r == 2) ? 32'h400 : 32'h0);
      check($sformatf("rst_busy_x%0d", r), 32'(rd_busy), 32'h0);
    end

    //   we wa  wd            ie ia fl a0 a1 d0            d1            b{1,0}
    add(1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 2, 32'hDEADBEEF, 32'h400,      2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        2'b00);
    add(1, 0,  32'h1234,     0, 0, 0, 0, 0, 32'h0,        32'h0,        2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 2'b00);
    add(0, 0,  32'h0,        1, 7, 0, 7, 7, 32'h0,        32'h0,        2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 7, 5, 32'h0,        32'hDEADBEEF, 2'b01);
    add(0, 0,  32'h0,        0, 0, 0, 7, 7, 32'h0,        32'h0,        2'b11);
    add(0, 0,  32'h0,        0, 0, 0, 5, 7, 32'hDEADBEEF, 32'h0,        2'b10);
    add(1, 7,  32'h55,       0, 0, 0, 7, 7, 32'h55,       32'h55,       2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 7, 7, 32'h55,       32'h55,       2'b00);
    add(0, 0,  32'h0,        1, 9, 0, 9, 0, 32'h0,        32'h0,        2'b00);
    add(1, 9,  32'hAA,       1, 9, 0, 9, 9, 32'hAA,       32'hAA,       2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 9, 5, 32'hAA,       32'hDEADBEEF, 2'b01);
    add(0, 0,  32'h0,        1, 3, 0, 3, 9, 32'h0,        32'hAA,       2'b10);
    add(0, 0,  32'h0,        1, 4, 0, 3, 4, 32'h0,        32'h0,        2'b01);
    add(0, 0,  32'h0,        1, 6, 1, 3, 4, 32'h0,        32'h0,        2'b11);
    add(0, 0,  32'h0,        0, 0, 0, 6, 3, 32'h0,        32'h0,        2'b00);
    add(0, 0,  32'h0,        1, 0, 0, 4, 9, 32'h0,        32'hAA,       2'b00);
    add(0, 0,  32'h0,        0, 0, 0, 0, 2, 32'h0,        32'h400,      2'b00);

    foreach (vq[i]) begin
      wr_en = vq[i].we; wr_addr = vq[i].wa; wr_data = vq[i].wd;
      issue_en = vq[i].ie; issue_addr = vq[i].ia; flush = vq[i].fl;
      rd_addr = {vq[i].a1, vq[i].a0};
      #1;
      check($sformatf("v%0d_d0", i), rd_data[31:0],  vq[i].d0);
      check($sformatf("v%0d_d1", i), rd_data[63:32], vq[i].d1);
      check($sformatf("v%0d_busy", i), 32'(rd_busy), 32'(vq[i].b));
      @(negedge clk);
    end
    idle_inputs();

    // Mid-cycle async reset with a write pending: write lost, scoreboard cleared
    issue_en = 1'b1; issue_addr = 5'd12;
    @(negedge clk);
    issue_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h99;
    rd_addr = {5'd12, 5'd5};
    #1;
    check("pre_rst_busy12", 32'(rd_busy[1]), 32'h1);
    #1;
    async_reset = 1'b0;
    #1;
    wr_en = 1'b0;
    rd_addr = {5'd2, 5'd5};
    #1;
    check("rst_mid_x5", rd_data[31:0],  32'h0);
    check("rst_mid_sp", rd_data[63:32], 32'h400);
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    rd_addr = {5'd12, 5'd9};
    #1;
    check("rst_mid_x9",     rd_data[31:0], 32'h0);
    check("rst_mid_busy",   32'(rd_busy),  32'h0);
    async_reset = 1'b1;
    @(negedge clk);
    rd_addr = {5'd7, 5'd5};
    #1;
    check("post_rst_x5", rd_data[31:0],  32'h0);
    check("post_rst_x7", rd_data[63:32], 32'h0);
    check("post_rst_busy", 32'(rd_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
